// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared opcode, error and state types for the stack sequencer
package stack_ctrl_pkg;

  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_PUSH = 3'b000,
    OP_POP  = 3'b001,
    OP_TOS  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_AND  = 3'b101,
    OP_NOT  = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_UNDER = 2'b01,
    ERR_OVER  = 2'b10,
    ERR_ILL   = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_POP1, S_CAP1, S_POP2, S_CAP2, S_PUSHR, S_DONE
  } state_e;

  function automatic logic is_binary(op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - command/response handshake bundle of the stack sequencer
interface stack_ctrl_if #(parameter int W = 8);

  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/stack_ctrl_alu.sv
// rtl/stack_ctrl_alu.sv - combinational ALU; a is the deeper operand, b the top
module stack_alu
  import stack_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_NOT:  y = ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - sequencer driving push/pop/tos strobes of the 32-entry stack
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  stack_ctrl_if.slave   bus,
  output logic          stk_push,
  output logic          stk_pop,
  output logic          stk_tos,
  output logic [W-1:0]  stk_din,
  input  logic [W-1:0]  stk_dout,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

  state_e        state;
  op_e           op_q;
  logic [W-1:0]  data_q;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  rsp_data_q;
  err_e          rsp_err_q;
  logic [DW-1:0] depth_q;
  logic [W-1:0]  alu_y;
  op_e           cmd_op_e;
  err_e          chk_err;

  assign cmd_op_e = op_e'(bus.cmd_op);

  stack_alu #(.W(W)) u_alu (
    .op (op_q),
    .a  (opa),
    .b  (opb),
    .y  (alu_y)
  );

  // Legality is judged against the depth at accept time; the sequence never re-checks.
  always_comb begin
    chk_err = ERR_OK;
    case (cmd_op_e)
      OP_ILL:                  chk_err = ERR_ILL;
      OP_PUSH:                 if (depth_q == DEPTH_C) chk_err = ERR_OVER;
      OP_POP, OP_TOS, OP_NOT:  if (depth_q == '0) chk_err = ERR_UNDER;
      default:                 if (depth_q < DW'(2)) chk_err = ERR_UNDER;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= OP_PUSH;
      data_q     <= '0;
      opa        <= '0;
      opb        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OK;
      depth_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q      <= cmd_op_e;
            data_q    <= bus.cmd_data;
            rsp_err_q <= chk_err;
            if (chk_err != ERR_OK) begin
              rsp_data_q <= '0;
              state      <= S_DONE;
            end else if (cmd_op_e == OP_PUSH) begin
              state <= S_PUSH;
            end else begin
              state <= S_POP1;
            end
          end
        end
        S_PUSH: begin
          depth_q    <= depth_q + DW'(1);
          rsp_data_q <= data_q;
          state      <= S_DONE;
        end
        S_POP1: begin
          if (op_q != OP_TOS) depth_q <= depth_q - DW'(1);
          state <= S_CAP1;
        end
        S_CAP1: begin
          opb <= stk_dout;
          if (op_q == OP_POP || op_q == OP_TOS) begin
            rsp_data_q <= stk_dout;
            state      <= S_DONE;
          end else if (is_binary(op_q)) begin
            state <= S_POP2;
          end else begin
            state <= S_PUSHR;
          end
        end
        S_POP2: begin
          depth_q <= depth_q - DW'(1);
          state   <= S_CAP2;
        end
        S_CAP2: begin
          opa   <= stk_dout;
          state <= S_PUSHR;
        end
        S_PUSHR: begin
          depth_q    <= depth_q + DW'(1);
          rsp_data_q <= alu_y;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes come straight from the state register so they are one cycle wide and exclusive.
  assign stk_push = (state == S_PUSH) || (state == S_PUSHR);
  assign stk_pop  = ((state == S_POP1) && (op_q != OP_TOS)) || (state == S_POP2);
  assign stk_tos  = (state == S_POP1) && (op_q == OP_TOS);
  assign stk_din  = (state == S_PUSH)  ? data_q :
                    (state == S_PUSHR) ? alu_y  : '0;

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  assign depth = depth_q;
  assign full  = (depth_q == DEPTH_C);
  assign empty = (depth_q == '0);

endmodule
